// File: rtl/pipe_checker_pkg.sv
// Shared definitions for the pipeline checker: FSM state encoding, counter width,
// latency limits and a saturating increment used by both statistic counters.
package pipe_check_pkg;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_FILL  = 2'd1;
  localparam logic [1:0] STATE_CHECK = 2'd2;
  localparam logic [1:0] STATE_HALT  = 2'd3;

  localparam int COUNTER_WIDTH      = 16;
  localparam int MIN_LATENCY        = 1;
  localparam int MAX_LATENCY        = 8;
  localparam int FILL_COUNTER_WIDTH = $clog2(MAX_LATENCY);

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [COUNTER_WIDTH-1:0] satIncrement(input logic [COUNTER_WIDTH-1:0] value);
    return (value == '1) ? value : value + COUNTER_WIDTH'(1);
  endfunction

endpackage

// File: rtl/pipe_checker_expected_delay_line.sv
// Shift register that delays the predicted result and its valid bit by the DUT
// latency; it shifts on every edge so bubbles keep their place in the stream.
module expected_delay_line
  import pipe_check_pkg::*;
#(
  parameter int numberOfBits = 8,
  parameter int latency      = 2
) (
  input  logic                    clock_i,
  input  logic                    nReset_i,
  input  logic [numberOfBits-1:0] data_i,
  input  logic                    valid_i,
  output logic [numberOfBits-1:0] data_o,
  output logic                    valid_o
);

  logic [numberOfBits-1:0] data_q [latency];
  logic [latency-1:0]      valid_q;

  always_ff @(posedge clock_i) begin
    if (!nReset_i) begin
      valid_q <= '0;
      for (int i = 0; i < latency; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= data_i;
      for (int i = 1; i < latency; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign data_o  = data_q[latency-1];
  assign valid_o = valid_q[latency-1];

endmodule

// File: rtl/pipe_checker.sv
// Checks a two-adder DUT: predicts its result, delays the prediction by the DUT
// latency and compares, counting comparisons and mismatches until maxErrors.
module pipe_checker
  import pipe_check_pkg::*;
#(
  parameter int numberOfBits = 8,
  parameter int latency      = 2,
  parameter int maxErrors    = 4
) (
  input  logic                     clock_i,
  input  logic                     nReset_i,
  input  logic                     stimValid_i,
  input  logic [numberOfBits-1:0]  leftAdderLeftInput_i,
  input  logic [numberOfBits-1:0]  leftAdderRightInput_i,
  input  logic [numberOfBits-1:0]  rightAdderLeftInput_i,
  input  logic [numberOfBits-1:0]  rightAdderRightInput_i,
  input  logic [numberOfBits-1:0]  result_i,
  output logic [numberOfBits-1:0]  expected_o,
  output logic                     compareValid_o,
  output logic                     mismatch_o,
  output logic [COUNTER_WIDTH-1:0] errorCount_o,
  output logic [COUNTER_WIDTH-1:0] checkCount_o,
  output logic                     pass_o,
  output logic                     halted_o
);

  localparam logic [FILL_COUNTER_WIDTH-1:0] FILL_LOAD = FILL_COUNTER_WIDTH'(latency - 1);

  logic [1:0]                    state_q, state_d;
  logic [FILL_COUNTER_WIDTH-1:0] fillCount_q, fillCount_d;
  logic [numberOfBits-1:0]       expected_q, expected_d;
  logic                          compareValid_q, compareValid_d;
  logic                          mismatch_q, mismatch_d;
  logic [COUNTER_WIDTH-1:0]      errorCount_q, errorCount_d;
  logic [COUNTER_WIDTH-1:0]      checkCount_q, checkCount_d;

  logic [numberOfBits-1:0] leftSum, rightSum, expectedNow, delayedExpected;
  logic                    delayedValid, doCompare, isMismatch, reachLimit;

  assign leftSum     = leftAdderLeftInput_i + leftAdderRightInput_i;
  assign rightSum    = rightAdderLeftInput_i + rightAdderRightInput_i;
  assign expectedNow = leftSum + rightSum;

  expected_delay_line #(
    .numberOfBits(numberOfBits),
    .latency     (latency)
  ) delayLine (
    .clock_i (clock_i),
    .nReset_i(nReset_i),
    .data_i  (expectedNow),
    .valid_i (stimValid_i),
    .data_o  (delayedExpected),
    .valid_o (delayedValid)
  );

  assign doCompare  = delayedValid && (state_q == STATE_CHECK);
  assign isMismatch = doCompare && (result_i != delayedExpected);
  assign reachLimit = isMismatch && ((32'(errorCount_q) + 32'd1) >= 32'(maxErrors));

  // FILL lasts latency-1 cycles so CHECK is reached exactly when the first sample emerges.
  always_comb begin
    state_d     = state_q;
    fillCount_d = fillCount_q;
    case (state_q)
      STATE_IDLE: begin
        if (stimValid_i) begin
          if (latency == 1) begin
            state_d = STATE_CHECK;
          end else begin
            state_d     = STATE_FILL;
            fillCount_d = FILL_LOAD;
          end
        end
      end
      STATE_FILL: begin
        if (fillCount_q <= FILL_COUNTER_WIDTH'(1)) begin
          state_d     = STATE_CHECK;
          fillCount_d = '0;
        end else begin
          fillCount_d = fillCount_q - FILL_COUNTER_WIDTH'(1);
        end
      end
      STATE_CHECK: begin
        if (reachLimit) begin
          state_d = STATE_HALT;
        end
      end
      STATE_HALT: begin
        state_d = STATE_HALT;
      end
      default: begin
        state_d = STATE_IDLE;
      end
    endcase
  end

  always_comb begin
    compareValid_d = doCompare;
    mismatch_d     = isMismatch;
    expected_d     = doCompare ? delayedExpected : expected_q;
    checkCount_d   = doCompare ? satIncrement(checkCount_q) : checkCount_q;
    errorCount_d   = isMismatch ? satIncrement(errorCount_q) : errorCount_q;
  end

  always_ff @(posedge clock_i) begin
    if (!nReset_i) begin
      state_q        <= STATE_IDLE;
      fillCount_q    <= '0;
      expected_q     <= '0;
      compareValid_q <= 1'b0;
      mismatch_q     <= 1'b0;
      errorCount_q   <= '0;
      checkCount_q   <= '0;
    end else begin
      state_q        <= state_d;
      fillCount_q    <= fillCount_d;
      expected_q     <= expected_d;
      compareValid_q <= compareValid_d;
      mismatch_q     <= mismatch_d;
      errorCount_q   <= errorCount_d;
      checkCount_q   <= checkCount_d;
    end
  end

  assign expected_o     = expected_q;
  assign compareValid_o = compareValid_q;
  assign mismatch_o     = mismatch_q;
  assign errorCount_o   = errorCount_q;
  assign checkCount_o   = checkCount_q;
  assign pass_o         = (state_q == STATE_CHECK) && (errorCount_q == '0);
  assign halted_o       = (state_q == STATE_HALT);

endmodule

// File: tb/tb_pipe_checker.sv
// Self-checking bench for pipe_checker: directed scenarios plus a randomized
// stream compared against a queue-based reference model.
module tb_pipe_checker;

  localparam int NB     = 8;
  localparam int LAT    = 2;
  localparam int MAXERR = 3;

  logic          clock;
  logic          nReset;
  logic          stimValid;
  logic [NB-1:0] leftLeft, leftRight, rightLeft, rightRight, result;
  logic [NB-1:0] expected;
  logic          compareValid, mismatch, pass, halted;
  logic [15:0]   errorCount, checkCount;

  int failCount  = 0;
  int checkTotal = 0;

  typedef struct packed {
    logic          valid;
    logic [NB-1:0] value;
  } sample_t;

  // Reference model: samples in flight, plus what the outputs should show after each edge.
  sample_t       mQueue[$];
  bit            mStarted, mHalted, mCompareValid, mMismatch, mPass;
  int            mEdge, mStartEdge, mErrors, mChecks;
  logic [NB-1:0] mExpected;

  pipe_checker #(
    .numberOfBits(NB),
    .latency     (LAT),
    .maxErrors   (MAXERR)
  ) dut (
    .clock_i               (clock),
    .nReset_i              (nReset),
    .stimValid_i           (stimValid),
    .leftAdderLeftInput_i  (leftLeft),
    .leftAdderRightInput_i (leftRight),
    .rightAdderLeftInput_i (rightLeft),
    .rightAdderRightInput_i(rightRight),
    .result_i              (result),
    .expected_o            (expected),
    .compareValid_o        (compareValid),
    .mismatch_o            (mismatch),
    .errorCount_o          (errorCount),
    .checkCount_o          (checkCount),
    .pass_o                (pass),
    .halted_o              (halted)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [NB-1:0] refSum(input int a, input int b, input int c, input int d);
    return NB'((a + b + c + d) % (1 << NB));
  endfunction

  task automatic modelReset();
    sample_t empty;
    empty = '0;
    mQueue.delete();
    for (int i = 0; i < LAT; i++) mQueue.push_back(empty);
    mStarted      = 1'b0;
    mHalted       = 1'b0;
    mCompareValid = 1'b0;
    mMismatch     = 1'b0;
    mPass         = 1'b0;
    mEdge         = 0;
    mStartEdge    = 0;
    mErrors       = 0;
    mChecks       = 0;
    mExpected     = '0;
  endtask

  // Drives one cycle; result is the correct DUT answer unless forceResult is set.
  task automatic stepCycle(input bit rstN, input bit v, input int a, input int b, input int c,
                           input int d, input bit forceResult, input logic [NB-1:0] forcedValue);
    sample_t head;
    sample_t fresh;
    nReset     = rstN;
    stimValid  = v;
    leftLeft   = NB'(a);
    leftRight  = NB'(b);
    rightLeft  = NB'(c);
    rightRight = NB'(d);
    result     = forceResult ? forcedValue : mQueue[0].value;
    @(posedge clock);
    if (!rstN) begin
      modelReset();
    end else begin
      head          = mQueue.pop_front();
      mCompareValid = head.valid && mStarted && !mHalted;
      mMismatch     = mCompareValid && (result !== head.value);
      if (mCompareValid) begin
        mExpected = head.value;
        mChecks++;
      end
      if (mMismatch) begin
        mErrors++;
        if (mErrors >= MAXERR) mHalted = 1'b1;
      end
      fresh.valid = v;
      fresh.value = refSum(a, b, c, d);
      mQueue.push_back(fresh);
      if (v && !mStarted) begin
        mStarted   = 1'b1;
        mStartEdge = mEdge;
      end
      mPass = mStarted && !mHalted && ((mEdge - mStartEdge) >= LAT - 1) && (mErrors == 0);
      mEdge++;
    end
    #1;
  endtask

  task automatic test_reset();
    stepCycle(0, 0, 0, 0, 0, 0, 0, '0);
    stepCycle(0, 1, 1, 2, 3, 4, 0, '0);
    checkTotal++;
    if (expected !== '0) begin failCount++; $display("[TB] FAIL reset_expected: got %0h want 0", expected); end
    checkTotal++;
    if (compareValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_compareValid: got %b want 0", compareValid); end
    checkTotal++;
    if (mismatch !== 1'b0) begin failCount++; $display("[TB] FAIL reset_mismatch: got %b want 0", mismatch); end
    checkTotal++;
    if (errorCount !== 16'd0) begin failCount++; $display("[TB] FAIL reset_errorCount: got %0d want 0", errorCount); end
    checkTotal++;
    if (checkCount !== 16'd0) begin failCount++; $display("[TB] FAIL reset_checkCount: got %0d want 0", checkCount); end
    checkTotal++;
    if (pass !== 1'b0) begin failCount++; $display("[TB] FAIL reset_pass: got %b want 0", pass); end
    checkTotal++;
    if (halted !== 1'b0) begin failCount++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
  endtask

  task automatic test_basic();
    int firstSeen = -1;
    int seen = 0;
    stepCycle(0, 0, 0, 0, 0, 0, 0, '0);
    for (int step = 0; step < 14; step++) begin
      if (step < 10) stepCycle(1, 1, step, step, step, step, 0, '0);
      else           stepCycle(1, 0, 0, 0, 0, 0, 0, '0);
      if (compareValid === 1'b1) begin
        if (firstSeen < 0) firstSeen = step + 1;
        checkTotal++;
        if (expected !== NB'(4 * seen)) begin
          failCount++; $display("[TB] FAIL basic_expected[%0d]: got %0h want %0h", seen, expected, NB'(4 * seen));
        end
        checkTotal++;
        if (mismatch !== 1'b0) begin failCount++; $display("[TB] FAIL basic_mismatch[%0d]: got %b want 0", seen, mismatch); end
        seen++;
      end
    end
    checkTotal++;
    if (firstSeen != LAT + 1) begin failCount++; $display("[TB] FAIL basic_first_compare: got %0d cycles want %0d", firstSeen, LAT + 1); end
    checkTotal++;
    if (seen != 10) begin failCount++; $display("[TB] FAIL basic_compare_pulses: got %0d want 10", seen); end
    checkTotal++;
    if (checkCount !== 16'd10) begin failCount++; $display("[TB] FAIL basic_checkCount: got %0d want 10", checkCount); end
    checkTotal++;
    if (errorCount !== 16'd0) begin failCount++; $display("[TB] FAIL basic_errorCount: got %0d want 0", errorCount); end
    checkTotal++;
    if (pass !== 1'b1) begin failCount++; $display("[TB] FAIL basic_pass: got %b want 1", pass); end
  endtask

  task automatic test_mismatch();
    int pulses = 0;
    logic [NB-1:0] pulseExpected = '0;
    bit corrupt;
    stepCycle(0, 0, 0, 0, 0, 0, 0, '0);
    for (int step = 0; step < 14; step++) begin
      corrupt = mQueue[0].valid && (mQueue[0].value == 8'h14);
      if (step < 10) stepCycle(1, 1, step, step, step, step, corrupt, 8'h15);
      else           stepCycle(1, 0, 0, 0, 0, 0, corrupt, 8'h15);
      if (mismatch === 1'b1) begin
        pulses++;
        pulseExpected = expected;
      end
    end
    checkTotal++;
    if (pulses != 1) begin failCount++; $display("[TB] FAIL mismatch_pulses: got %0d want 1", pulses); end
    checkTotal++;
    if (pulseExpected !== 8'h14) begin failCount++; $display("[TB] FAIL mismatch_expected: got %0h want 14", pulseExpected); end
    checkTotal++;
    if (errorCount !== 16'd1) begin failCount++; $display("[TB] FAIL mismatch_errorCount: got %0d want 1", errorCount); end
    checkTotal++;
    if (checkCount !== 16'd10) begin failCount++; $display("[TB] FAIL mismatch_checkCount: got %0d want 10", checkCount); end
    checkTotal++;
    if (pass !== 1'b0) begin failCount++; $display("[TB] FAIL mismatch_pass: got %b want 0", pass); end
    checkTotal++;
    if (halted !== 1'b0) begin failCount++; $display("[TB] FAIL mismatch_halted: got %b want 0", halted); end
  endtask

  task automatic test_wrap();
    logic [NB-1:0] seenValues [2];
    int seen = 0;
    int mismatches = 0;
    seenValues[0] = 8'hAA;
    seenValues[1] = 8'hAA;
    stepCycle(0, 0, 0, 0, 0, 0, 0, '0);
    stepCycle(1, 1, 8'h40, 8'h40, 8'h40, 8'h40, 0, '0);
    if (compareValid === 1'b1) begin if (seen < 2) seenValues[seen] = expected; seen++; end
    stepCycle(1, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, '0);
    if (compareValid === 1'b1) begin if (seen < 2) seenValues[seen] = expected; seen++; end
    for (int step = 0; step < 4; step++) begin
      stepCycle(1, 0, 0, 0, 0, 0, 0, '0);
      if (mismatch === 1'b1) mismatches++;
      if (compareValid === 1'b1) begin if (seen < 2) seenValues[seen] = expected; seen++; end
    end
    checkTotal++;
    if (seen != 2) begin failCount++; $display("[TB] FAIL wrap_compare_pulses: got %0d want 2", seen); end
    checkTotal++;
    if (seenValues[0] !== 8'h00) begin failCount++; $display("[TB] FAIL wrap_expected_40: got %0h want 00", seenValues[0]); end
    checkTotal++;
    if (seenValues[1] !== 8'hFC) begin failCount++; $display("[TB] FAIL wrap_expected_FF: got %0h want fc", seenValues[1]); end
    checkTotal++;
    if (mismatches != 0) begin failCount++; $display("[TB] FAIL wrap_mismatches: got %0d want 0", mismatches); end
  endtask

  task automatic test_halt();
    int pulses = 0;
    int lateCompares = 0;
    bit haltedBefore = 1'b0;
    stepCycle(0, 0, 0, 0, 0, 0, 0, '0);
    for (int step = 0; step < 12; step++) begin
      stepCycle(1, 1, 1, 2, 3, 4, 1, 8'h00);
      if (mismatch === 1'b1) pulses++;
      if (haltedBefore && (compareValid !== 1'b0)) lateCompares++;
      if (halted === 1'b1) haltedBefore = 1'b1;
    end
    checkTotal++;
    if (pulses != MAXERR) begin failCount++; $display("[TB] FAIL halt_pulses: got %0d want %0d", pulses, MAXERR); end
    checkTotal++;
    if (halted !== 1'b1) begin failCount++; $display("[TB] FAIL halt_halted: got %b want 1", halted); end
    checkTotal++;
    if (lateCompares != 0) begin failCount++; $display("[TB] FAIL halt_compare_after_halt: got %0d want 0", lateCompares); end
    checkTotal++;
    if (errorCount !== 16'(MAXERR)) begin failCount++; $display("[TB] FAIL halt_errorCount: got %0d want %0d", errorCount, MAXERR); end
    checkTotal++;
    if (checkCount !== 16'(MAXERR)) begin failCount++; $display("[TB] FAIL halt_checkCount: got %0d want %0d", checkCount, MAXERR); end
    checkTotal++;
    if (pass !== 1'b0) begin failCount++; $display("[TB] FAIL halt_pass: got %b want 0", pass); end
  endtask

  task automatic test_bubbles();
    int pulses = 0;
    stepCycle(0, 0, 0, 0, 0, 0, 0, '0);
    for (int step = 0; step < 11; step++) begin
      stepCycle(1, (step < 8) && (step % 2 == 0), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255), 0, '0);
      if (compareValid === 1'b1) pulses++;
    end
    checkTotal++;
    if (pulses != 4) begin failCount++; $display("[TB] FAIL bubbles_compare_pulses: got %0d want 4", pulses); end
    checkTotal++;
    if (checkCount !== 16'd4) begin failCount++; $display("[TB] FAIL bubbles_checkCount: got %0d want 4", checkCount); end
    checkTotal++;
    if (errorCount !== 16'd0) begin failCount++; $display("[TB] FAIL bubbles_errorCount: got %0d want 0", errorCount); end
  endtask

  task automatic test_midreset();
    int firstSeen = -1;
    logic [NB-1:0] firstExpected = '0;
    stepCycle(0, 0, 0, 0, 0, 0, 0, '0);
    for (int step = 1; step <= 5; step++) stepCycle(1, 1, step, step, step, step, 0, '0);
    stepCycle(0, 1, 7, 7, 7, 7, 0, '0);
    checkTotal++;
    if (compareValid !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_compareValid: got %b want 0", compareValid); end
    checkTotal++;
    if (checkCount !== 16'd0) begin failCount++; $display("[TB] FAIL midreset_checkCount: got %0d want 0", checkCount); end
    checkTotal++;
    if (expected !== '0) begin failCount++; $display("[TB] FAIL midreset_expected: got %0h want 0", expected); end
    checkTotal++;
    if (pass !== 1'b0 || halted !== 1'b0 || mismatch !== 1'b0 || errorCount !== 16'd0) begin
      failCount++; $display("[TB] FAIL midreset_status: got pass=%b halted=%b mismatch=%b errors=%0d want all 0",
                            pass, halted, mismatch, errorCount);
    end
    for (int step = 0; step < 8; step++) begin
      if (step < 4) stepCycle(1, 1, 2 + step, 3, 4, 5, 0, '0);
      else          stepCycle(1, 0, 0, 0, 0, 0, 0, '0);
      if ((compareValid === 1'b1) && (firstSeen < 0)) begin
        firstSeen     = step + 1;
        firstExpected = expected;
      end
    end
    checkTotal++;
    if (firstSeen != LAT + 1) begin failCount++; $display("[TB] FAIL midreset_first_compare: got %0d cycles want %0d", firstSeen, LAT + 1); end
    checkTotal++;
    if (firstExpected !== 8'h0E) begin failCount++; $display("[TB] FAIL midreset_first_expected: got %0h want 0e", firstExpected); end
    checkTotal++;
    if (checkCount !== 16'd4) begin failCount++; $display("[TB] FAIL midreset_checkCount: got %0d want 4", checkCount); end
  endtask

  task automatic test_random();
    bit corrupt;
    stepCycle(0, 0, 0, 0, 0, 0, 0, '0);
    for (int step = 0; step < 60; step++) begin
      corrupt = ($urandom_range(0, 15) == 0);
      stepCycle(1, $urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255), corrupt, mQueue[0].value ^ 8'h01);
      checkTotal++;
      if (compareValid !== mCompareValid) begin failCount++; $display("[TB] FAIL random_compareValid[%0d]: got %b want %b", step, compareValid, mCompareValid); end
      checkTotal++;
      if (mismatch !== mMismatch) begin failCount++; $display("[TB] FAIL random_mismatch[%0d]: got %b want %b", step, mismatch, mMismatch); end
      checkTotal++;
      if (expected !== mExpected) begin failCount++; $display("[TB] FAIL random_expected[%0d]: got %0h want %0h", step, expected, mExpected); end
      checkTotal++;
      if (errorCount !== 16'(mErrors)) begin failCount++; $display("[TB] FAIL random_errorCount[%0d]: got %0d want %0d", step, errorCount, mErrors); end
      checkTotal++;
      if (checkCount !== 16'(mChecks)) begin failCount++; $display("[TB] FAIL random_checkCount[%0d]: got %0d want %0d", step, checkCount, mChecks); end
      checkTotal++;
      if (pass !== mPass) begin failCount++; $display("[TB] FAIL random_pass[%0d]: got %b want %b", step, pass, mPass); end
      checkTotal++;
      if (halted !== mHalted) begin failCount++; $display("[TB] FAIL random_halted[%0d]: got %b want %b", step, halted, mHalted); end
    end
  endtask

  initial begin
    nReset     = 1'b0;
    stimValid  = 1'b0;
    leftLeft   = '0;
    leftRight  = '0;
    rightLeft  = '0;
    rightRight = '0;
    result     = '0;
    modelReset();
    $display("[TB] starting pipe_checker bench");
    test_reset();
    test_basic();
    test_mismatch();
    test_wrap();
    test_halt();
    test_bubbles();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", failCount, checkTotal);
    $finish;
  end

endmodule

// File: doc/pipe_checker.md
PIPE_CHECKER -- requirements
Module: pipe_checker

Interface
REQ-001 Parameter numberOfBits, default 8: width of adder operands, result and expected value.
REQ-002 Parameter latency, default 2: DUT clock cycles from an operand sample to the matching result; legal range 1..8.
REQ-003 Parameter maxErrors, default 4: error count at which checking halts; legal range 1..65535.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 nReset  in  1  reset; synchronous, active-low.
REQ-006 stimValid  in  1  operands on the four operand ports are a real sample this cycle.
REQ-007 leftAdderLeftInput, leftAdderRightInput, rightAdderLeftInput, rightAdderRightInput  in  numberOfBits each  operands driven to the DUT.
REQ-008 result  in  numberOfBits  DUT output.
REQ-009 expected  out  numberOfBits  expected value of the current comparison.
REQ-010 compareValid  out  1  high for one cycle per comparison performed.
REQ-011 mismatch  out  1  high for one cycle when a performed comparison fails.
REQ-012 errorCount  out  16  saturating count of mismatches.
REQ-013 checkCount  out  16  saturating count of comparisons.
REQ-014 pass  out  1  high while state is CHECK and errorCount is 0.
REQ-015 halted  out  1  high while state is HALT.

Function
REQ-016 Expected value: ((LL+LR) mod 2^numberOfBits + (RL+RR) mod 2^numberOfBits) mod 2^numberOfBits; every add wraps at numberOfBits.
REQ-017 Expected value and the stimValid bit enter a latency-deep delay line on every rising edge, bubbles included.
REQ-018 Operands sampled at edge k are compared against result sampled at edge k+latency.
REQ-019 compareValid, mismatch and expected are registered; they are visible in the cycle after edge k+latency.
REQ-020 A comparison is performed only if the delayed valid bit is 1 and state is CHECK; otherwise compareValid=0 and mismatch=0.
REQ-021 FSM states: IDLE, FILL, CHECK, HALT.
REQ-022 IDLE -> FILL on the first stimValid=1; the fill counter loads latency-1.
REQ-023 FILL decrements once per cycle; FILL -> CHECK when it reaches 0, so the first valid sample is compared.
REQ-024 CHECK -> HALT on the edge where errorCount would reach maxErrors; that mismatch is still counted and pulsed.
REQ-025 HALT is left only by reset; no comparisons and no counter updates occur in HALT.
REQ-026 errorCount and checkCount saturate at 16'hFFFF and do not wrap.
REQ-027 A stimValid=0 bubble produces no comparison and does not change state.

Reset
REQ-028 On a clock edge with nReset=0: state=IDLE, delay line cleared (all valid bits 0), fill counter 0, expected=0, compareValid=0, mismatch=0, errorCount=0, checkCount=0, pass=0, halted=0.
REQ-029 Reset asserted mid-run discards all in-flight samples; after release the block re-enters IDLE and refills before comparing.

Structure
REQ-030 Shared package pipe_check_pkg holds the FSM state encoding, the counter width constant (16) and the latency range limits.
REQ-031 The delay line is the sub-module expected_delay_line (parameters numberOfBits, latency; data plus valid shift register).

Verification
REQ-032 All four operands = i for i=0..9, stimValid=1, correct DUT, latency=2 -> compareValid first seen 3 cycles after the first sample; expected=4*i; checkCount=10; errorCount=0; pass=1.
REQ-033 Same stream, result forced to 8'h15 where 8'h14 is expected (i=5) -> one mismatch pulse on that comparison; errorCount=1; pass=0.
REQ-034 All operands 8'h40 -> expected=8'h00, matched against a DUT result of 8'h00; all operands 8'hFF -> expected=8'hFC.
REQ-035 maxErrors=3, result stuck at 0 with nonzero operands -> three mismatch pulses, then halted=1; compareValid stays 0 afterwards; errorCount stays 3.
REQ-036 Alternating stimValid 1/0 for 8 cycles -> exactly 4 comparisons; checkCount=4.
REQ-037 nReset low for one cycle mid-stream -> all outputs return to their reset values; the first comparison after reset occurs latency+1 cycles after the next valid sample.
